lcd_dma_sched: RTL
==================

Name: lcd_dma_sched

Overview:
- Sequences and shares the 8-word LCD parallel interface register window between the CPU bus and a framebuffer DMA engine.
- On start, optionally synchronised to the panel tearing signal (fmark), the DMA engine does the following:
  - writes a memory-write command word to the LCD command register (word 0);
  - streams COUNT pixels from memory into the LCD data register (word 1).
- CPU accesses to the LCD window are interleaved between DMA pixel transactions.

Parameters:
- MEM_AW, 24, word-address width of the memory read port.
- CNT_W, 18, width of the pixel counter (max 2^CNT_W-1 pixels per frame).

Ports:
- clk in 1 system clock
- nrst in 1 reset, asynchronous, active-low
- cpu_addr in 4 word address; 0-7 pass through to the LCD interface, 8-11 are scheduler registers
- cpu_wen in 1 CPU write request, held until cpu_ready
- cpu_ren in 1 CPU read request, held until cpu_ready
- cpu_wdata in 32 CPU write data
- cpu_rdata out 32 CPU read data, valid when cpu_ready
- cpu_ready out 1 CPU transaction complete
- l_addr out 3 LCD interface word address
- l_wen out 1 LCD interface write request
- l_ren out 1 LCD interface read request
- l_wdata out 32 LCD interface write data
- l_rdata in 32 LCD interface read data
- l_ready in 1 LCD interface transaction complete
- mem_addr out MEM_AW framebuffer word address
- mem_ren out 1 memory read request, held until mem_ready
- mem_rdata in 32 memory read data
- mem_ready in 1 memory read complete
- lcd_fmark in 1 raw tearing-effect pin (asynchronous)
- irq out 1 frame-done interrupt

Behaviour:
- Registers:
  - 8 CTRL (W):
    - bit0 START (self-clearing)
    - bit1 FMSYNC
    - bit2 ABORT (self-clearing)
    - bit3 IRQCLR (write-1-clear)
    - bit4 IRQEN
  - 8 CTRL (R): {27'b0, IRQEN, irq_pend, FMSYNC, busy, 1'b0}.
  - 9 BASE: MEM_AW bits.
  - 10 COUNT: CNT_W bits.
  - 11 CMD: 18 bits; reset value 0x2C.
- Scheduler-register accesses: cpu_ready is combinational in the same cycle as wen|ren; writes take effect on that edge.
- Reset values:
  - l_wen=0, l_ren=0, l_addr=0, l_wdata=0
  - mem_ren=0, mem_addr=0
  - irq=0, busy=0
  - BASE=0, COUNT=0, FMSYNC=0, IRQEN=0
  - state=IDLE
  - fmark synchroniser=0
- Asynchronous reset mid-transaction drops all requests immediately. No resume.
- Downstream handshake:
  - l_* requests are registered and held stable until the cycle l_ready=1.
  - The transaction completes on that edge; requests deassert on the next cycle.
  - Exactly one outstanding downstream transaction.
- fmark handling: 2-flop synchroniser, then rising-edge detect giving a 1-cycle pulse.
- DMA state machine:
  - IDLE: START with COUNT loaded → WAITFM if FMSYNC, else CMD. START while busy is ignored.
  - WAITFM: fmark rising edge → CMD.
  - CMD: downstream write addr 0, data=CMD. On completion → FETCH if remaining≠0, else DONE.
  - FETCH: mem_ren with mem_addr=BASE+index. On mem_ready, latch the word → PUSH.
  - PUSH: downstream write addr 1, data={14'b0, word[17:0]}. On completion: index+1, remaining-1; → FETCH if remaining≠0, else DONE.
  - DONE: busy=0, irq_pend=1 → IDLE.
- busy=1 in all states except IDLE.
- COUNT=0: command word still written, then DONE; no memory reads.
- Arbitration:
  - A pending CPU access to words 0-7 is granted only at a downstream boundary: while IDLE, or in place of the next DMA downstream transaction.
  - After a CPU grant the DMA gets the next slot (alternation), so neither side starves.
  - CPU data passes straight through: l_rdata→cpu_rdata, and cpu_ready=l_ready for the granted CPU transaction.
  - Simultaneous CPU request and DMA slot with no prior CPU grant: CPU wins.
- ABORT:
  - A downstream transaction or memory read already issued completes normally.
  - The engine then goes to IDLE without setting irq_pend.
  - In WAITFM, ABORT → IDLE on the next cycle.
- irq = irq_pend & IRQEN. IRQCLR and DONE in the same cycle: set wins.
- Index arithmetic: mem_addr wraps modulo 2^MEM_AW.

Optional Feature:
- Macro: LCD_DMA_PACK16_EN.
- When defined:
  - CTRL bit5 PACK16 becomes read/write.
  - With PACK16=1 each memory word holds two RGB565 pixels, low half first.
  - Each half is expanded to 18 bits as {r[4:0], r[4], g[5:0], b[4:0], b[4]}.
  - One FETCH is followed by two PUSH transactions.
  - With odd COUNT, the high half of the last word is discarded.
  - COUNT still counts pixels.
- When undefined: bit5 reads 0 and writes are ignored; one pixel per word.

Test Plan:
- COUNT=3, BASE=0x100, FMSYNC=0, START:
  - downstream writes: addr0=0x2C, then addr1 with mem[0x100..0x102][17:0];
  - mem_addr sequence 0x100, 0x101, 0x102;
  - irq after DONE when IRQEN=1.
- FMSYNC=1, START, fmark held low for 50 cycles then pulsed high: no downstream activity before the pulse; the CMD write starts ≤4 cycles after the fmark edge.
- CPU write to word 2 while a 4-pixel DMA is in progress:
  - exactly one DMA pixel write precedes the CPU write;
  - the CPU write appears with addr2 and cpu_wdata intact;
  - the remaining pixels follow.
- COUNT=0, START: only the addr0 command write occurs, mem_ren never asserts, irq_pend=1.
- ABORT during FETCH with mem_ready delayed 5 cycles:
  - the memory read completes;
  - no further downstream writes occur;
  - busy falls, irq_pend stays 0.
- nrst asserted while l_wen=1 mid-pixel: l_wen, mem_ren and irq are 0 asynchronously; CTRL reads 0 and CMD reads 0x2C after release.

Source files
------------

// File: rtl/lcd_dma_sched.sv
// Shares the 8-word LCD register window between the CPU bus and a framebuffer DMA engine.
// Define LCD_DMA_PACK16_EN to enable two RGB565 pixels per memory word (CTRL bit5 PACK16).
module lcd_dma_sched #(
    parameter int MEM_AW = 24,
    parameter int CNT_W  = 18
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [3:0]        cpu_addr,
    input  logic              cpu_wen,
    input  logic              cpu_ren,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ready,
    output logic [2:0]        l_addr,
    output logic              l_wen,
    output logic              l_ren,
    output logic [31:0]       l_wdata,
    input  logic [31:0]       l_rdata,
    input  logic              l_ready,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_ren,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    input  logic              lcd_fmark,
    output logic              irq
);
    typedef enum logic [2:0] {S_IDLE, S_WAITFM, S_CMD, S_FETCH, S_PUSH, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              l_wen_q, l_wen_d, l_ren_q, l_ren_d;
    logic [2:0]        l_addr_q, l_addr_d;
    logic [31:0]       l_wdata_q, l_wdata_d;
    logic              own_cpu_q, own_cpu_d, last_cpu_q, last_cpu_d;
    logic              mem_ren_q, mem_ren_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d, base_q, base_d, index_q, index_d;
    logic [CNT_W-1:0]  count_q, count_d, remain_q, remain_d;
    logic [17:0]       cmd_q, cmd_d;
    logic [31:0]       word_q, word_d;
    logic              fmsync_q, fmsync_d, irqen_q, irqen_d, irq_pend_q, irq_pend_d;
    logic              abort_q, abort_d;
    logic [2:0]        fm_sync_q, fm_sync_d;
    logic              pack16_bit;
    logic [17:0]       pix;

    logic dn_busy, dma_busy, dma_done, dma_req, cpu_lcd_req, grant_cpu, grant_dma;
    logic reg_hit, reg_we, ctrl_we, start_wr, abort_wr, fm_pulse, busy;
    logic [31:0] reg_rdata;

`ifdef LCD_DMA_PACK16_EN
    logic        pack16_q, pack16_d, half_q, half_d;
    logic [15:0] p16;
    assign p16        = half_q ? word_q[31:16] : word_q[15:0];
    assign pix        = pack16_q ? {p16[15:11], p16[15], p16[10:5], p16[4:0], p16[4]} : word_q[17:0];
    assign pack16_bit = pack16_q;
`else
    logic unused_word;
    assign unused_word = ^word_q[31:18];
    assign pix         = word_q[17:0];
    assign pack16_bit  = 1'b0;
`endif

    assign busy        = (state_q != S_IDLE);
    assign dn_busy     = l_wen_q | l_ren_q;
    assign dma_busy    = dn_busy & ~own_cpu_q;
    assign dma_done    = dma_busy & l_ready;
    assign dma_req     = ((state_q == S_CMD) || (state_q == S_PUSH)) && !abort_q;
    assign cpu_lcd_req = (cpu_wen | cpu_ren) & ~cpu_addr[3];
    // After a CPU grant the DMA wins the next contested slot, so neither side starves.
    assign grant_cpu   = !dn_busy && cpu_lcd_req && (!dma_req || !last_cpu_q);
    assign grant_dma   = !dn_busy && dma_req && !grant_cpu;
    assign reg_hit     = (cpu_addr[3:2] == 2'b10);
    assign reg_we      = cpu_wen & reg_hit;
    assign ctrl_we     = reg_we && (cpu_addr[1:0] == 2'd0);
    assign start_wr    = ctrl_we & cpu_wdata[0];
    assign abort_wr    = ctrl_we & cpu_wdata[2];
    assign fm_pulse    = fm_sync_q[1] & ~fm_sync_q[2];

    always_comb begin
        reg_rdata = '0;
        if (reg_hit) begin
            case (cpu_addr[1:0])
                2'd0:    reg_rdata = {26'b0, pack16_bit, irqen_q, irq_pend_q, fmsync_q, busy, 1'b0};
                2'd1:    reg_rdata[MEM_AW-1:0] = base_q;
                2'd2:    reg_rdata[CNT_W-1:0] = count_q;
                default: reg_rdata[17:0] = cmd_q;
            endcase
        end
    end

    assign cpu_rdata = cpu_addr[3] ? reg_rdata : l_rdata;
    assign cpu_ready = cpu_addr[3] ? (cpu_wen | cpu_ren) : (own_cpu_q & dn_busy & l_ready);

    always_comb begin
        state_d    = state_q;
        l_wen_d    = l_wen_q;
        l_ren_d    = l_ren_q;
        l_addr_d   = l_addr_q;
        l_wdata_d  = l_wdata_q;
        own_cpu_d  = own_cpu_q;
        last_cpu_d = last_cpu_q;
        mem_ren_d  = mem_ren_q;
        mem_addr_d = mem_addr_q;
        base_d     = base_q;
        index_d    = index_q;
        count_d    = count_q;
        remain_d   = remain_q;
        cmd_d      = cmd_q;
        word_d     = word_q;
        fmsync_d   = fmsync_q;
        irqen_d    = irqen_q;
        irq_pend_d = irq_pend_q;
        abort_d    = abort_q;
        fm_sync_d  = {fm_sync_q[1:0], lcd_fmark};
`ifdef LCD_DMA_PACK16_EN
        pack16_d   = pack16_q;
        half_d     = half_q;
`endif
        if (reg_we) begin
            case (cpu_addr[1:0])
                2'd0: begin
                    fmsync_d = cpu_wdata[1];
                    irqen_d  = cpu_wdata[4];
`ifdef LCD_DMA_PACK16_EN
                    pack16_d = cpu_wdata[5];
`endif
                    if (cpu_wdata[3]) irq_pend_d = 1'b0;
                end
                2'd1:    base_d  = cpu_wdata[MEM_AW-1:0];
                2'd2:    count_d = cpu_wdata[CNT_W-1:0];
                default: cmd_d   = cpu_wdata[17:0];
            endcase
        end

        if (dn_busy && l_ready) begin
            l_wen_d = 1'b0;
            l_ren_d = 1'b0;
        end else if (grant_cpu) begin
            l_wen_d    = cpu_wen;
            l_ren_d    = cpu_ren;
            l_addr_d   = cpu_addr[2:0];
            l_wdata_d  = cpu_wdata;
            own_cpu_d  = 1'b1;
            last_cpu_d = 1'b1;
        end else if (grant_dma) begin
            l_wen_d    = 1'b1;
            l_addr_d   = (state_q == S_CMD) ? 3'd0 : 3'd1;
            l_wdata_d  = (state_q == S_CMD) ? {14'b0, cmd_q} : {14'b0, pix};
            own_cpu_d  = 1'b0;
            last_cpu_d = 1'b0;
        end

        case (state_q)
            S_IDLE: if (start_wr) begin
                remain_d = count_q;
                index_d  = '0;
`ifdef LCD_DMA_PACK16_EN
                half_d   = 1'b0;
`endif
                state_d  = cpu_wdata[1] ? S_WAITFM : S_CMD;
            end
            S_WAITFM: begin
                if (abort_q)       state_d = S_IDLE;
                else if (fm_pulse) state_d = S_CMD;
            end
            S_CMD: begin
                if (dma_done) begin
                    if (abort_q) state_d = S_IDLE;
                    else if (remain_q != '0) begin
                        state_d    = S_FETCH;
                        mem_ren_d  = 1'b1;
                        mem_addr_d = base_q + index_q;
                    end else state_d = S_DONE;
                end else if (abort_q && !dma_busy) state_d = S_IDLE;
            end
            S_FETCH: if (mem_ren_q && mem_ready) begin
                mem_ren_d = 1'b0;
                word_d    = mem_rdata;
                state_d   = abort_q ? S_IDLE : S_PUSH;
            end
            S_PUSH: begin
                if (dma_done) begin
                    remain_d = remain_q - CNT_W'(1);
                    if (abort_q) state_d = S_IDLE;
`ifdef LCD_DMA_PACK16_EN
                    else if (pack16_q && !half_q && remain_d != '0) half_d = 1'b1;
`endif
                    else begin
`ifdef LCD_DMA_PACK16_EN
                        half_d  = 1'b0;
`endif
                        index_d = index_q + MEM_AW'(1);
                        if (remain_d != '0) begin
                            state_d    = S_FETCH;
                            mem_ren_d  = 1'b1;
                            mem_addr_d = base_q + index_d;
                        end else state_d = S_DONE;
                    end
                end else if (abort_q && !dma_busy) state_d = S_IDLE;
            end
            default: begin
                irq_pend_d = 1'b1;
                state_d    = S_IDLE;
            end
        endcase

        // Abort is only meaningful while running and is forgotten once the engine parks.
        if (abort_wr && state_q != S_IDLE) abort_d = 1'b1;
        if (state_d == S_IDLE)             abort_d = 1'b0;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= S_IDLE;
            l_wen_q    <= 1'b0;
            l_ren_q    <= 1'b0;
            l_addr_q   <= '0;
            l_wdata_q  <= '0;
            own_cpu_q  <= 1'b0;
            last_cpu_q <= 1'b0;
            mem_ren_q  <= 1'b0;
            mem_addr_q <= '0;
            base_q     <= '0;
            index_q    <= '0;
            count_q    <= '0;
            remain_q   <= '0;
            cmd_q      <= 18'h2C;
            word_q     <= '0;
            fmsync_q   <= 1'b0;
            irqen_q    <= 1'b0;
            irq_pend_q <= 1'b0;
            abort_q    <= 1'b0;
            fm_sync_q  <= '0;
`ifdef LCD_DMA_PACK16_EN
            pack16_q   <= 1'b0;
            half_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            l_wen_q    <= l_wen_d;
            l_ren_q    <= l_ren_d;
            l_addr_q   <= l_addr_d;
            l_wdata_q  <= l_wdata_d;
            own_cpu_q  <= own_cpu_d;
            last_cpu_q <= last_cpu_d;
            mem_ren_q  <= mem_ren_d;
            mem_addr_q <= mem_addr_d;
            base_q     <= base_d;
            index_q    <= index_d;
            count_q    <= count_d;
            remain_q   <= remain_d;
            cmd_q      <= cmd_d;
            word_q     <= word_d;
            fmsync_q   <= fmsync_d;
            irqen_q    <= irqen_d;
            irq_pend_q <= irq_pend_d;
            abort_q    <= abort_d;
            fm_sync_q  <= fm_sync_d;
`ifdef LCD_DMA_PACK16_EN
            pack16_q   <= pack16_d;
            half_q     <= half_d;
`endif
        end
    end

    assign l_wen    = l_wen_q;
    assign l_ren    = l_ren_q;
    assign l_addr   = l_addr_q;
    assign l_wdata  = l_wdata_q;
    assign mem_ren  = mem_ren_q;
    assign mem_addr = mem_addr_q;
    assign irq      = irq_pend_q & irqen_q;
endmodule
